door_pad_sequencer: RTL and testbench
=====================================

Name: door_pad_sequencer

Overview:
- Front-end for the store occupancy counter.
- Takes the two raw, asynchronous, bouncy door pressure pads: outer pad (street side) and inner pad (store side).
- Synchronises and debounces both pads, then tracks the step order with a direction FSM.
- Emits exactly one single-cycle pressure_in pulse per completed entry and one pressure_out pulse per completed exit. These pulses feed the occupancy counter's pressure_in/pressure_out inputs directly.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required before a debounced level changes (1 ms at 50 MHz).
- TIMEOUT_CYCLES, 250000000: maximum cycles the FSM may remain in any single walking state before aborting (5 s at 50 MHz).

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- pad_outer_raw, input, 1: raw outer pad, asynchronous, 1 = pressed.
- pad_inner_raw, input, 1: raw inner pad, asynchronous, 1 = pressed.
- pressure_in, output, 1: one-cycle pulse when an entry completes.
- pressure_out, output, 1: one-cycle pulse when an exit completes.
- busy, output, 1: high whenever the FSM is not in IDLE.
- timeout_err, output, 1: one-cycle pulse when a walking state times out.
- state_dbg, output, 3: current FSM state encoding, for debug.

Behaviour:
- Reset: one clock is synchronous, active-high reset.
  - Synchronisers, debounced levels o/i, debounce counters, timer and all outputs go to 0.
  - FSM goes to IDLE (state_dbg = 0).
  - Reset mid-sequence discards the sequence with no pulse.
- Synchroniser: 2-flop synchroniser per pad.
- Debounce, per pad:
  - Counter increments while the synced value differs from the debounced level. It clears whenever they are equal.
  - On reaching DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - Latency from a clean raw edge to the debounced edge is 2 + DEBOUNCE_CYCLES clocks.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- FSM states and encodings: IDLE=0, ENT1=1, ENT2=2, ENT3=3, EXT1=4, EXT2=5, EXT3=6, WAIT_CLR=7. Transitions are evaluated each cycle on (o,i).
  - IDLE: (1,0)->ENT1; (0,1)->EXT1; (1,1)->WAIT_CLR; (0,0) stays.
  - ENT1: (1,1)->ENT2; (0,0)->IDLE (backed out, no pulse); (0,1)->WAIT_CLR.
  - ENT2: (0,1)->ENT3; (1,0)->ENT1; (0,0)->WAIT_CLR.
  - ENT3: (0,0)->IDLE and pressure_in fires; (1,1)->ENT2; (1,0)->WAIT_CLR.
  - EXT1/EXT2/EXT3: mirror of ENT1/ENT2/ENT3 with o and i swapped. Completion from EXT3 on (0,0) fires pressure_out.
  - WAIT_CLR: (0,0)->IDLE, never produces a pulse. Any (o,i) pattern not listed above holds the current state.
- Pulse timing:
  - pressure_in/pressure_out are registered and high for exactly the one cycle following the clock edge on which the FSM leaves ENT3/EXT3 for IDLE.
  - Each pulse is low on every other cycle.
  - pressure_in and pressure_out are never high together.
  - Back-to-back people: the minimum spacing between pulses is set by the debounce latency, and each completed walk yields exactly one pulse.
- Timeout:
  - The state timer clears on every state change and while in IDLE or WAIT_CLR.
  - When the timer reaches TIMEOUT_CYCLES in ENT1..EXT3, the FSM goes to WAIT_CLR and timeout_err pulses for one cycle, with no pressure pulse.
  - A pad still held after timeout keeps the FSM in WAIT_CLR until both pads are released.
- busy = (state != IDLE), registered with the state.
- Counter widths: sized to hold DEBOUNCE_CYCLES and TIMEOUT_CYCLES. Counters never wrap; they clear as specified above.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=100.
- Clean entry: outer=1 (20 cyc), both=1 (20), inner only (20), none -> exactly one pressure_in pulse, 7 cycles (2 sync + 4 debounce + 1 register) after the inner release; pressure_out stays 0; busy falls on the same edge.
- Clean exit: mirror order, inner first -> exactly one pressure_out pulse; state_dbg walks 4,5,6,0.
- Bounce rejection: 3-cycle glitches on outer every 10 cycles for 200 cycles, inner idle -> state_dbg stays 0, no pulses. Then a clean entry -> exactly one pressure_in pulse.
- Backout: outer 20 cyc, both 20, outer only 20, release -> no pulses, return to IDLE. Abort from ENT2 to (0,0) -> WAIT_CLR then IDLE, no pulse.
- Timeout: outer held 300 cycles -> timeout_err pulses once about 100 cycles after ENT1 entry; state 7 until release; then IDLE, no pressure_in.
- Reset mid-walk: assert reset for 1 cycle while in ENT3 -> on the next edge all outputs = 0 and state 0; subsequent inner release produces no pulse.

Source files
------------

// File: rtl/door_pad_sequencer.sv
// Door pressure-pad front end: per-pad sync + debounce, then a step-order FSM
// that turns a completed walk across both pads into one entry/exit pulse.

module pad_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);
  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      // cnt holds consecutive disagreeing cycles; the Nth one flips the level
      if (sync[1] != level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level <= ~level;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module door_pad_sequencer #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int TIMEOUT_CYCLES  = 250000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pad_outer_raw,
  input  logic       pad_inner_raw,
  output logic       pressure_in,
  output logic       pressure_out,
  output logic       busy,
  output logic       timeout_err,
  output logic [2:0] state_dbg
);
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ENT1     = 3'd1,
    ENT2     = 3'd2,
    ENT3     = 3'd3,
    EXT1     = 3'd4,
    EXT2     = 3'd5,
    EXT3     = 3'd6,
    WAIT_CLR = 3'd7
  } state_t;

  logic [1:0] raw, lvl;
  assign raw = {pad_outer_raw, pad_inner_raw};

  for (genvar g = 0; g < 2; g++) begin : g_pad
    pad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (raw[g]),
      .level (lvl[g])
    );
  end

  // pads = {outer, inner}
  logic [1:0]    pads;
  state_t        state, nxt_state;
  logic [TW-1:0] timer;
  logic          walking, nxt_in, nxt_out, nxt_to;

  assign pads      = lvl;
  assign walking   = (state != IDLE) && (state != WAIT_CLR);
  assign state_dbg = state;

  always_comb begin
    nxt_state = state;
    nxt_in    = 1'b0;
    nxt_out   = 1'b0;
    nxt_to    = 1'b0;
    unique case (state)
      IDLE: case (pads)
        2'b10:   nxt_state = ENT1;
        2'b01:   nxt_state = EXT1;
        2'b11:   nxt_state = WAIT_CLR;
        default: ;
      endcase
      ENT1: case (pads)
        2'b11:   nxt_state = ENT2;
        2'b00:   nxt_state = IDLE;
        2'b01:   nxt_state = WAIT_CLR;
        default: ;
      endcase
      ENT2: case (pads)
        2'b01:   nxt_state = ENT3;
        2'b10:   nxt_state = ENT1;
        2'b00:   nxt_state = WAIT_CLR;
        default: ;
      endcase
      ENT3: case (pads)
        2'b00: begin
          nxt_state = IDLE;
          nxt_in    = 1'b1;
        end
        2'b11:   nxt_state = ENT2;
        2'b10:   nxt_state = WAIT_CLR;
        default: ;
      endcase
      EXT1: case (pads)
        2'b11:   nxt_state = EXT2;
        2'b00:   nxt_state = IDLE;
        2'b10:   nxt_state = WAIT_CLR;
        default: ;
      endcase
      EXT2: case (pads)
        2'b10:   nxt_state = EXT3;
        2'b01:   nxt_state = EXT1;
        2'b00:   nxt_state = WAIT_CLR;
        default: ;
      endcase
      EXT3: case (pads)
        2'b00: begin
          nxt_state = IDLE;
          nxt_out   = 1'b1;
        end
        2'b11:   nxt_state = EXT2;
        2'b01:   nxt_state = WAIT_CLR;
        default: ;
      endcase
      WAIT_CLR: if (pads == 2'b00) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase

    // a pad step on the expiry cycle wins over the timeout
    if (walking && (nxt_state == state) && (timer == TW'(TIMEOUT_CYCLES - 1))) begin
      nxt_state = WAIT_CLR;
      nxt_to    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      pressure_in  <= 1'b0;
      pressure_out <= 1'b0;
      timeout_err  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= nxt_state;
      pressure_in  <= nxt_in;
      pressure_out <= nxt_out;
      timeout_err  <= nxt_to;
      busy         <= (nxt_state != IDLE);
      if (!walking || (nxt_state != state)) timer <= '0;
      else                                  timer <= timer + 1'b1;
    end
  end
endmodule

// File: tb/tb_door_pad_sequencer.sv
// Bench for door_pad_sequencer: directed walks plus random pad traffic,
// checked against a table-driven reference model of the pad/step rules.

module tb_door_pad_sequencer;
  localparam int DB = 4;
  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       pad_outer_raw, pad_inner_raw;
  logic       pressure_in, pressure_out, busy, timeout_err;
  logic [2:0] state_dbg;

  int tests = 0, fails = 0;
  int dut_in = 0, dut_out = 0, dut_to = 0, mdl_in = 0, mdl_out = 0, mism = 0;

  always #5 clk = ~clk;

  door_pad_sequencer #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .pad_outer_raw(pad_outer_raw),
    .pad_inner_raw(pad_inner_raw),
    .pressure_in  (pressure_in),
    .pressure_out (pressure_out),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .state_dbg    (state_dbg)
  );

  // ---------------- reference model ----------------
  // trans[state*4 + {o,i}] = next state; unlisted patterns hold.
  int trans [32];

  task automatic set_tr(input int s, input int o, input int i, input int n);
    trans[s*4 + o*2 + i] = n;
  endtask

  initial begin
    for (int s = 0; s < 8; s++)
      for (int p = 0; p < 4; p++) trans[s*4 + p] = s;
    set_tr(0, 1, 0, 1); set_tr(0, 0, 1, 4); set_tr(0, 1, 1, 7);
    set_tr(1, 1, 1, 2); set_tr(1, 0, 0, 0); set_tr(1, 0, 1, 7);
    set_tr(2, 0, 1, 3); set_tr(2, 1, 0, 1); set_tr(2, 0, 0, 7);
    set_tr(3, 0, 0, 0); set_tr(3, 1, 1, 2); set_tr(3, 1, 0, 7);
    set_tr(4, 1, 1, 5); set_tr(4, 0, 0, 0); set_tr(4, 1, 0, 7);
    set_tr(5, 1, 0, 6); set_tr(5, 0, 1, 4); set_tr(5, 0, 0, 7);
    set_tr(6, 0, 0, 0); set_tr(6, 1, 1, 5); set_tr(6, 0, 1, 7);
    set_tr(7, 0, 0, 0);
  end

  function automatic bit f_tmo(input int st, input logic [1:0] p, input int age);
    return (trans[st*4 + int'(p)] == st) && (st >= 1) && (st <= 6) && (age == TO);
  endfunction

  function automatic int f_step(input int st, input logic [1:0] p, input int age);
    return f_tmo(st, p, age) ? 7 : trans[st*4 + int'(p)];
  endfunction

  logic [1:0]    m_r1, m_r2, m_lvl;
  logic [DB-1:0] m_win [2];
  int            m_st = 0, m_enter = 0, cyc = 0;
  logic          m_pin, m_pout, m_busy, m_terr;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_r1 <= '0; m_r2 <= '0; m_lvl <= '0;
      m_win[0] <= '0; m_win[1] <= '0;
      m_st <= 0; m_enter <= cyc;
      m_pin <= 1'b0; m_pout <= 1'b0; m_busy <= 1'b0; m_terr <= 1'b0;
    end else begin
      m_r1 <= {pad_outer_raw, pad_inner_raw};
      m_r2 <= m_r1;
      // a level flips once DB consecutive synced samples disagree with it
      for (int p = 0; p < 2; p++) begin
        if (&{m_win[p][DB-2:0], m_r2[p] != m_lvl[p]}) begin
          m_lvl[p] <= ~m_lvl[p];
          m_win[p] <= '0;
        end else begin
          m_win[p] <= {m_win[p][DB-2:0], m_r2[p] != m_lvl[p]};
        end
      end
      m_st   <= f_step(m_st, m_lvl, cyc - m_enter);
      m_terr <= f_tmo(m_st, m_lvl, cyc - m_enter);
      m_busy <= f_step(m_st, m_lvl, cyc - m_enter) != 0;
      m_pin  <= (m_st == 3) && (f_step(m_st, m_lvl, cyc - m_enter) == 0);
      m_pout <= (m_st == 6) && (f_step(m_st, m_lvl, cyc - m_enter) == 0);
      if (f_step(m_st, m_lvl, cyc - m_enter) != m_st) m_enter <= cyc;
    end
  end

  // cycle-by-cycle agreement and pulse tallies, sampled 2 ns after the edge
  always begin
    @(posedge clk);
    #2;
    if (state_dbg !== 3'(m_st) || busy !== m_busy || pressure_in !== m_pin ||
        pressure_out !== m_pout || timeout_err !== m_terr) mism = mism + 1;
    if (pressure_in === 1'b1 && pressure_out === 1'b1) mism = mism + 1;
    if (pressure_in === 1'b1)  dut_in  = dut_in + 1;
    if (pressure_out === 1'b1) dut_out = dut_out + 1;
    if (timeout_err === 1'b1)  dut_to  = dut_to + 1;
    if (m_pin)  mdl_in  = mdl_in + 1;
    if (m_pout) mdl_out = mdl_out + 1;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: run exceeded time limit, required completion");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  task automatic hold(input logic o, input logic i, input int n);
    pad_outer_raw = o;
    pad_inner_raw = i;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    hold(1'b0, 1'b0, 3);
    tests++;
    if ({pressure_in, pressure_out, busy, timeout_err, state_dbg} !== 7'd0) begin
      fails++;
      $display("FAIL reset_outputs: got in=%b out=%b busy=%b to=%b st=%0d, required all 0",
               pressure_in, pressure_out, busy, timeout_err, state_dbg);
    end
    reset = 1'b0;
    hold(1'b0, 1'b0, 10);
    tests++;
    if (state_dbg !== 3'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: got st=%0d busy=%b, required st=0 busy=0", state_dbg, busy);
    end
  endtask

  task automatic test_clean_entry;
    int i0, o0, m0, lat;
    logic prev_busy, busy_at;
    i0 = dut_in; o0 = dut_out; m0 = mism; lat = -1; prev_busy = 1'b0; busy_at = 1'b1;
    hold(1, 0, 20); hold(1, 1, 20); hold(0, 1, 20);
    tests++;
    if (state_dbg !== 3'd3) begin
      fails++;
      $display("FAIL entry_ent3: got st=%0d, required 3", state_dbg);
    end
    pad_outer_raw = 0; pad_inner_raw = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (lat < 0 && pressure_in === 1'b1) begin
        lat = n;
        busy_at = busy;
      end
      if (lat < 0) prev_busy = busy;
    end
    tests++;
    if (lat !== 7) begin
      fails++;
      $display("FAIL entry_latency: got %0d cycles, required 7", lat);
    end
    tests++;
    if (busy_at !== 1'b0 || prev_busy !== 1'b1) begin
      fails++;
      $display("FAIL entry_busy_fall: got before=%b at=%b, required 1 then 0", prev_busy, busy_at);
    end
    tests++;
    if (dut_in - i0 !== 1 || dut_out - o0 !== 0) begin
      fails++;
      $display("FAIL entry_pulses: got in=%0d out=%0d, required in=1 out=0", dut_in - i0, dut_out - o0);
    end
    tests++;
    if (mism - m0 !== 0) begin
      fails++;
      $display("FAIL entry_model: got %0d differing cycles, required 0", mism - m0);
    end
  endtask

  task automatic test_clean_exit;
    int i0, o0;
    logic [2:0] s1, s2, s3, s4;
    i0 = dut_in; o0 = dut_out;
    hold(0, 1, 20); s1 = state_dbg;
    hold(1, 1, 20); s2 = state_dbg;
    hold(1, 0, 20); s3 = state_dbg;
    hold(0, 0, 20); s4 = state_dbg;
    tests++;
    if ({s1, s2, s3, s4} !== {3'd4, 3'd5, 3'd6, 3'd0}) begin
      fails++;
      $display("FAIL exit_walk: got %0d,%0d,%0d,%0d, required 4,5,6,0", s1, s2, s3, s4);
    end
    tests++;
    if (dut_out - o0 !== 1 || dut_in - i0 !== 0) begin
      fails++;
      $display("FAIL exit_pulses: got in=%0d out=%0d, required in=0 out=1", dut_in - i0, dut_out - o0);
    end
  endtask

  task automatic test_bounce;
    int i0, o0, m0, nonidle;
    i0 = dut_in; o0 = dut_out; m0 = mism; nonidle = 0;
    for (int k = 0; k < 20; k++) begin
      pad_outer_raw = 1; pad_inner_raw = 0;
      repeat (3) begin @(negedge clk); if (state_dbg !== 3'd0) nonidle++; end
      pad_outer_raw = 0;
      repeat (7) begin @(negedge clk); if (state_dbg !== 3'd0) nonidle++; end
    end
    tests++;
    if (nonidle !== 0 || dut_in != i0 || dut_out != o0) begin
      fails++;
      $display("FAIL bounce_reject: got %0d non-idle cycles, %0d pulses, required 0 and 0",
               nonidle, (dut_in - i0) + (dut_out - o0));
    end
    hold(1, 0, 20); hold(1, 1, 20); hold(0, 1, 20); hold(0, 0, 20);
    tests++;
    if (dut_in - i0 !== 1 || mism - m0 !== 0) begin
      fails++;
      $display("FAIL bounce_then_entry: got in=%0d diff=%0d, required in=1 diff=0", dut_in - i0, mism - m0);
    end
  endtask

  task automatic test_backout;
    int i0, o0, seen7, after;
    i0 = dut_in; o0 = dut_out; seen7 = 0; after = -1;
    hold(1, 0, 20); hold(1, 1, 20); hold(1, 0, 20);
    tests++;
    if (state_dbg !== 3'd1) begin
      fails++;
      $display("FAIL backout_ent1: got st=%0d, required 1", state_dbg);
    end
    hold(0, 0, 20);
    tests++;
    if (state_dbg !== 3'd0 || dut_in != i0 || dut_out != o0) begin
      fails++;
      $display("FAIL backout_idle: got st=%0d pulses=%0d, required st=0 pulses=0",
               state_dbg, (dut_in - i0) + (dut_out - o0));
    end
    hold(1, 0, 20); hold(1, 1, 20);
    pad_outer_raw = 0; pad_inner_raw = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (seen7 == 1 && after < 0) after = state_dbg;
      if (state_dbg === 3'd7 && seen7 == 0) seen7 = 1;
    end
    tests++;
    if (seen7 !== 1 || after !== 0) begin
      fails++;
      $display("FAIL abort_ent2: got wait_seen=%0d next_st=%0d, required 1 and 0", seen7, after);
    end
    tests++;
    if (dut_in != i0 || dut_out != o0) begin
      fails++;
      $display("FAIL abort_pulses: got %0d, required 0", (dut_in - i0) + (dut_out - o0));
    end
  endtask

  task automatic test_timeout;
    int i0, t0, ent, tmo;
    i0 = dut_in; t0 = dut_to; ent = -1; tmo = -1;
    pad_outer_raw = 1; pad_inner_raw = 0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (ent < 0 && state_dbg === 3'd1) ent = n;
      if (tmo < 0 && timeout_err === 1'b1) tmo = n;
    end
    tests++;
    if (ent < 0 || tmo < 0 || tmo - ent < 99 || tmo - ent > 101) begin
      fails++;
      $display("FAIL timeout_delay: got ent=%0d err=%0d, required err about 100 after ent", ent, tmo);
    end
    tests++;
    if (dut_to - t0 !== 1 || state_dbg !== 3'd7) begin
      fails++;
      $display("FAIL timeout_hold: got pulses=%0d st=%0d, required 1 and 7", dut_to - t0, state_dbg);
    end
    hold(0, 0, 20);
    tests++;
    if (state_dbg !== 3'd0 || dut_in != i0) begin
      fails++;
      $display("FAIL timeout_release: got st=%0d in=%0d, required 0 and 0", state_dbg, dut_in - i0);
    end
  endtask

  task automatic test_reset_mid;
    int i0, o0, m0;
    hold(1, 0, 20); hold(1, 1, 20); hold(0, 1, 20);
    tests++;
    if (state_dbg !== 3'd3) begin
      fails++;
      $display("FAIL midreset_ent3: got st=%0d, required 3", state_dbg);
    end
    i0 = dut_in; o0 = dut_out; m0 = mism;
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({pressure_in, pressure_out, busy, timeout_err, state_dbg} !== 7'd0) begin
      fails++;
      $display("FAIL midreset_outputs: got in=%b out=%b busy=%b to=%b st=%0d, required all 0",
               pressure_in, pressure_out, busy, timeout_err, state_dbg);
    end
    reset = 1'b0;
    hold(0, 1, 20); hold(0, 0, 20);
    tests++;
    if (dut_in != i0 || dut_out != o0 || state_dbg !== 3'd0 || mism != m0) begin
      fails++;
      $display("FAIL midreset_release: got pulses=%0d st=%0d diff=%0d, required 0,0,0",
               (dut_in - i0) + (dut_out - o0), state_dbg, mism - m0);
    end
  endtask

  task automatic test_back_to_back;
    int i0, o0;
    i0 = dut_in; o0 = dut_out;
    repeat (3) begin hold(1, 0, 8); hold(1, 1, 8); hold(0, 1, 8); hold(0, 0, 8); end
    repeat (2) begin hold(0, 1, 8); hold(1, 1, 8); hold(1, 0, 8); hold(0, 0, 8); end
    hold(0, 0, 12);
    tests++;
    if (dut_in - i0 !== 3 || dut_out - o0 !== 2) begin
      fails++;
      $display("FAIL back_to_back: got in=%0d out=%0d, required in=3 out=2", dut_in - i0, dut_out - o0);
    end
  endtask

  task automatic test_random;
    int m0, i0, o0, mi0, mo0, walks_in, walks_out;
    m0 = mism; i0 = dut_in; o0 = dut_out; mi0 = mdl_in; mo0 = mdl_out;
    walks_in = 0; walks_out = 0;
    for (int w = 0; w < 40; w++) begin
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          hold(1, 0, $urandom_range(6, 20)); hold(1, 1, $urandom_range(6, 20));
          hold(0, 1, $urandom_range(6, 20)); walks_in++;
        end else begin
          hold(0, 1, $urandom_range(6, 20)); hold(1, 1, $urandom_range(6, 20));
          hold(1, 0, $urandom_range(6, 20)); walks_out++;
        end
      end else begin
        for (int k = 0; k < $urandom_range(2, 6); k++) begin
          logic [1:0] p;
          p = 2'($urandom_range(0, 3));
          hold(p[1], p[0], ($urandom_range(0, 9) == 0) ? $urandom_range(100, 130)
                                                      : $urandom_range(1, 25));
        end
      end
      hold(0, 0, 20);
    end
    tests++;
    if (mism - m0 !== 0) begin
      fails++;
      $display("FAIL random_model: got %0d differing cycles, required 0", mism - m0);
    end
    tests++;
    if (dut_in - i0 !== mdl_in - mi0 || dut_out - o0 !== mdl_out - mo0) begin
      fails++;
      $display("FAIL random_counts: got in=%0d out=%0d, required in=%0d out=%0d",
               dut_in - i0, dut_out - o0, mdl_in - mi0, mdl_out - mo0);
    end
    tests++;
    if (dut_in - i0 < walks_in || dut_out - o0 < walks_out) begin
      fails++;
      $display("FAIL random_walks: got in=%0d out=%0d, required at least %0d and %0d",
               dut_in - i0, dut_out - o0, walks_in, walks_out);
    end
  endtask

  initial begin
    reset = 1'b1;
    pad_outer_raw = 1'b0;
    pad_inner_raw = 1'b0;
    @(negedge clk);
    test_reset;
    test_clean_entry;
    test_clean_exit;
    test_bounce;
    test_backout;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    test_random;
    tests++;
    if (mism !== 0) begin
      fails++;
      $display("FAIL overall_model: got %0d differing cycles, required 0", mism);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
